div_seq: RTL and testbench

//   Multi-cycle radix-2 restoring divider sequencer for the EX stage HI/LO datapath.

---
 rtl/div_seq.sv | 171 +++++++++++++++++
 tb/tb_div_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for the EX-stage HI/LO path; result_o = {remainder, quotient}.
// Define DIV_SIGNED_EN to honour signed_i (DIV); without it every divide is unsigned (DIVU).
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic                  annul_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   prem;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   dvsr;
  logic                neg_q;
  logic                neg_r;

  logic                sgn_a;
  logic                sgn_b;
  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic                accept;
  logic                last_step;

  logic [DATA_W:0]     shifted;
  logic [DATA_W+1:0]   trial;
  logic                trial_ok;
  logic [DATA_W-1:0]   prem_nxt;
  logic [DATA_W-1:0]   quo_nxt;
  logic [DATA_W-1:0]   q_fix;
  logic [DATA_W-1:0]   r_fix;

`ifdef DIV_SIGNED_EN
  assign sgn_a = signed_i & opdata1_i[DATA_W-1];
  assign sgn_b = signed_i & opdata2_i[DATA_W-1];
`else
  logic unused_signed;
  assign unused_signed = signed_i;
  assign sgn_a = 1'b0;
  assign sgn_b = 1'b0;
`endif

  // The core always divides magnitudes; signs are reapplied on the final step.
  assign abs_a     = sgn_a ? (~opdata1_i + 1'b1) : opdata1_i;
  assign abs_b     = sgn_b ? (~opdata2_i + 1'b1) : opdata2_i;
  assign accept    = start_i & ~annul_i;
  assign last_step = (cnt == CNT_W'(DATA_W-1));

  // One restoring step: the dividend is shifted out of quo into prem while quotient bits shift in.
  always_comb begin
    shifted  = {prem, quo[DATA_W-1]};
    trial    = {1'b0, shifted} - {2'b00, dvsr};
    trial_ok = ~trial[DATA_W+1];
    prem_nxt = trial_ok ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_nxt  = {quo[DATA_W-2:0], trial_ok};
    q_fix    = neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
    r_fix    = neg_r ? (~prem_nxt + 1'b1) : prem_nxt;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; annul_i wins over start_i everywhere.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        next_state = annul_i ? S_IDLE : S_END;
      end
      S_ON: begin
        if (annul_i) begin
          next_state = S_IDLE;
        end else if (last_step) begin
          next_state = S_END;
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    stallreq_o = start_i & ~ready_o & ~annul_i;
  end

  // Datapath and registered result/ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      prem     <= '0;
      quo      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt   <= '0;
            prem  <= '0;
            quo   <= abs_a;
            dvsr  <= abs_b;
            neg_q <= sgn_a ^ sgn_b;
            neg_r <= sgn_a;
          end
        end
        S_BYZERO: begin
          if (!annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end
        S_ON: begin
          if (!annul_i) begin
            prem <= prem_nxt;
            quo  <= quo_nxt;
            cnt  <= cnt + 1'b1;
            if (last_step) begin
              result_o <= {r_fix, q_fix};
              ready_o  <= 1'b1;
            end
          end
        end
        S_END: begin
          if (annul_i || !start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed scenarios plus randomized divides against an arithmetic model.
module tb_div_seq;

  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           start;
  logic           signed_in;
  logic           annul;
  logic [W-1:0]   opdata1;
  logic [W-1:0]   opdata2;
  logic [2*W-1:0] result;
  logic           ready;
  logic           stallreq;

  logic [2*W-1:0] exp_q[$];
  int             n_checks;
  int             n_fail;

  div_seq #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .signed_i   (signed_in),
    .annul_i    (annul),
    .opdata1_i  (opdata1),
    .opdata2_i  (opdata2),
    .result_o   (result),
    .ready_o    (ready),
    .stallreq_o (stallreq)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain integer division on 64-bit values, so the
  // most-negative / -1 case needs no special handling.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sgn);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    if (sgn && SIGNED_BUILD) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // Driver: starts a divide at the beginning of a cycle and follows it to ready_o.
  // Returns one cycle after ready_o, with start still high (DUT in END).
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    int             lat;
    bit             seen;
    logic [2*W-1:0] exp;
    lat = (b == '0) ? 3 : W + 2;
    exp_q.push_back(model(a, b, sgn));
    opdata1   = a;
    opdata2   = b;
    signed_in = sgn;
    annul     = 1'b0;
    start     = 1'b1;
    seen      = 1'b0;
    for (int cyc = 1; cyc <= W + 6 && !seen; cyc++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        seen = 1'b1;
        exp  = exp_q.pop_front();
        n_checks += 2;
        if (cyc !== lat) begin
          n_fail++;
          $display("FAIL latency %h/%h: ready in cycle %0d, expected cycle %0d", a, b, cyc, lat);
        end
        if (result !== exp) begin
          n_fail++;
          $display("FAIL result %h/%h s=%0d: got %h expected %h", a, b, sgn, result, exp);
        end
      end else begin
        n_checks++;
        if (stallreq !== 1'b1) begin
          n_fail++;
          $display("FAIL stallreq cycle %0d: got %b expected 1", cyc, stallreq);
        end
      end
      @(posedge clk); #1;
      // Operands are registered on accept, so wiggling them must not matter.
      opdata1   = $urandom;
      opdata2   = $urandom;
      signed_in = 1'(($urandom_range(0, 1)));
    end
    if (!seen) begin
      void'(exp_q.pop_front());
      n_checks++;
      n_fail++;
      $display("FAIL timeout %h/%h: ready never rose", a, b);
    end
  endtask

  task automatic drop_start();
    start = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    n_checks += 2;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_ready: got %b expected 0", ready);
    end
    if (result !== '0) begin
      n_fail++;
      $display("FAIL drop_result: got %h expected 0", result);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_in = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks += 3;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stallreq); end
  endtask

  task automatic test_basic();
    run_div(32'd100, 32'd7, 1'b0);
    n_checks++;
    if (result !== {32'h2, 32'hE}) begin
      n_fail++; $display("FAIL basic_100_7: got %h expected %h", result, {32'h2, 32'hE});
    end
    drop_start();
  endtask

  task automatic test_byzero();
    run_div(32'd5, 32'd0, 1'b0);
    drop_start();
  endtask

  task automatic test_signed();
    logic [2*W-1:0] exp;
    exp = SIGNED_BUILD ? {32'hFFFFFFFF, 32'hFFFFFFFD} : {32'h1, 32'h7FFFFFFC};
    run_div(32'hFFFFFFF9, 32'h2, 1'b1);
    n_checks++;
    if (result !== exp) begin
      n_fail++; $display("FAIL signed_m7_2: got %h expected %h", result, exp);
    end
    drop_start();
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1);
    drop_start();
  endtask

  task automatic test_annul_idle();
    opdata1 = 32'd1000; opdata2 = 32'd10; start = 1'b1; annul = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (stallreq !== 1'b0) begin n_fail++; $display("FAIL annul_idle_stall: got %b expected 0", stallreq); end
      if (ready !== 1'b0) begin n_fail++; $display("FAIL annul_idle_ready: got %b expected 0", ready); end
      @(posedge clk); #1;
    end
    run_div(32'd1000, 32'd10, 1'b0);
    drop_start();
  endtask

  task automatic test_annul();
    opdata1 = 32'd100; opdata2 = 32'd7; signed_in = 1'b0; start = 1'b1; annul = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc == 10) annul = 1'b1;
      @(negedge clk);
      n_checks += 2;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL annul_ready c%0d: got %b expected 0", cyc, ready); end
      if (stallreq !== (cyc != 10)) begin
        n_fail++; $display("FAIL annul_stall c%0d: got %b expected %b", cyc, stallreq, cyc != 10);
      end
      @(posedge clk); #1;
    end
    run_div(32'd9, 32'd3, 1'b0);
    n_checks++;
    if (result !== {32'h0, 32'h3}) begin
      n_fail++; $display("FAIL annul_then_9_3: got %h expected %h", result, {32'h0, 32'h3});
    end
    drop_start();
  endtask

  task automatic test_hold_end();
    logic [2*W-1:0] exp;
    exp = model(32'hDEADBEEF, 32'h1234, 1'b0);
    run_div(32'hDEADBEEF, 32'h1234, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready %0d: got %b expected 1", i, ready); end
      if (result !== exp) begin n_fail++; $display("FAIL hold_result %0d: got %h expected %h", i, result, exp); end
      @(posedge clk); #1;
    end
    drop_start();
  endtask

  task automatic test_reset_mid();
    opdata1 = 32'h12345678; opdata2 = 32'd3; signed_in = 1'b0; start = 1'b1; annul = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    n_checks += 2;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_on_ready: got %b expected 0", ready); end
    if (result !== '0) begin n_fail++; $display("FAIL rst_on_result: got %h expected 0", result); end
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    // Reset while the result is being presented must clear it without a clock edge.
    run_div(32'd50, 32'd5, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_checks += 2;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_end_ready: got %b expected 0", ready); end
    if (result !== '0) begin n_fail++; $display("FAIL rst_end_result: got %h expected 0", result); end
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_div(32'h80000000, 32'd1, 1'b0);
    n_checks++;
    if (result !== {32'h0, 32'h80000000}) begin
      n_fail++; $display("FAIL rst_fresh_min_1: got %h expected %h", result, {32'h0, 32'h80000000});
    end
    drop_start();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         s;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      run_div(a, b, s);
      drop_start();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_byzero();
    test_signed();
    test_annul_idle();
    test_annul();
    test_hold_end();
    test_reset_mid();
    test_random();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: %0d expected results left unconsumed", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
